uart_param_top: RTL

UART_PARAM_TOP -- requirements
Module: uart_param_top

---
 rtl/uart_param_top.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_param_top.sv
`default_nettype none
// ============================================================================
// Module   : uart_param_top
// Purpose  : Parameterised UART with a TX framer and an RX deframer feeding a
//            show-ahead word FIFO. Optional parity bit: define UART_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
module uart_param_top #(
    parameter int DATA_BITS     = 8,
    parameter int CLK_PER_BIT   = 5208,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4,
    parameter int PARITY_ODD    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 busy,
    output logic                 tx_out,
    input  logic                 rx_in,
    input  logic                 rx_rd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 done,
    output logic                 rx_ovf,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int                c_baud_w    = $clog2(CLK_PER_BIT);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLK_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_half = c_baud_w'(CLK_PER_BIT / 2 - 1);
    localparam logic [3:0]        c_data_last = 4'(DATA_BITS - 1);
    localparam logic [3:0]        c_stop_last = 4'(STOP_BITS - 1);
    localparam int                c_idx_w     = $clog2(RX_FIFO_DEPTH);
    localparam int                c_ptr_w     = c_idx_w + 1;
`ifdef UART_PARITY_EN
    localparam logic              c_par_odd   = (PARITY_ODD != 0);
`endif

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || CLK_PER_BIT < 8 ||
            (STOP_BITS != 1 && STOP_BITS != 2) ||
            RX_FIFO_DEPTH < 2 || RX_FIFO_DEPTH > 16 ||
            (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0 ||
            (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
            $error("uart_param_top: illegal parameter value");
        end
    endgenerate

    // ------------------------------------------------------------------ TX
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    tx_state_t              r_tx_state, w_tx_next;
    logic [c_baud_w-1:0]    r_tx_baud;
    logic [3:0]             r_tx_bit;
    logic [DATA_BITS-1:0]   r_tx_shift;
    logic                   w_tx_baud_end;
`ifdef UART_PARITY_EN
    logic                   r_tx_par;
`endif

    assign w_tx_baud_end = (r_tx_baud == c_baud_last);
    assign busy          = (r_tx_state != TX_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_tx_state <= TX_IDLE;
        else      r_tx_state <= w_tx_next;
    end

    // tx_out decodes straight from state so reset drives the line high at once
    always_comb begin
        w_tx_next = r_tx_state;
        tx_out    = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                if (start) w_tx_next = TX_START;
            end
            TX_START: begin
                tx_out = 1'b0;
                if (w_tx_baud_end) w_tx_next = TX_DATA;
            end
            TX_DATA: begin
                tx_out = r_tx_shift[0];
                if (w_tx_baud_end && r_tx_bit == c_data_last) begin
`ifdef UART_PARITY_EN
                    w_tx_next = TX_PARITY;
`else
                    w_tx_next = TX_STOP;
`endif
                end
            end
            TX_PARITY: begin
`ifdef UART_PARITY_EN
                tx_out = r_tx_par;
                if (w_tx_baud_end) w_tx_next = TX_STOP;
`else
                w_tx_next = TX_IDLE;
`endif
            end
            TX_STOP: begin
                if (w_tx_baud_end && r_tx_bit == c_stop_last) w_tx_next = TX_IDLE;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else if (r_tx_state == TX_IDLE) begin
            r_tx_baud <= '0;
            r_tx_bit  <= '0;
            if (start) begin
                r_tx_shift <= data_in;
`ifdef UART_PARITY_EN
                r_tx_par   <= (^data_in) ^ c_par_odd;
`endif
            end
        end else begin
            r_tx_baud <= w_tx_baud_end ? '0 : r_tx_baud + 1'b1;
            if (w_tx_next != r_tx_state) r_tx_bit <= '0;
            else if (w_tx_baud_end)      r_tx_bit <= r_tx_bit + 1'b1;
            if (r_tx_state == TX_DATA && w_tx_baud_end) r_tx_shift <= r_tx_shift >> 1;
        end
    end

    // ------------------------------------------------------------------ RX
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    rx_state_t              r_rx_state, w_rx_next;
    logic                   r_rx_meta, r_rx_sync, r_rx_prev;
    logic [c_baud_w-1:0]    r_rx_baud;
    logic [3:0]             r_rx_bit;
    logic [DATA_BITS-1:0]   r_rx_shift;
    logic                   r_push, r_frame_err, r_rx_ovf;
    logic                   w_rx_fall, w_rx_baud_end, w_rx_stop_sample;
`ifdef UART_PARITY_EN
    logic                   r_rx_par_bit, r_parity_err, w_rx_par_bad;
    assign w_rx_par_bad = r_rx_par_bit != ((^r_rx_shift) ^ c_par_odd);
    assign parity_err   = r_parity_err;
`else
    assign parity_err   = 1'b0;
`endif

    // prev resets low, so a start edge needs the line to be seen high first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b0;
            r_rx_sync <= 1'b0;
            r_rx_prev <= 1'b0;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall        = r_rx_prev & ~r_rx_sync;
    assign w_rx_baud_end    = (r_rx_state == RX_START) ? (r_rx_baud == c_baud_half)
                                                       : (r_rx_baud == c_baud_last);
    assign w_rx_stop_sample = (r_rx_state == RX_STOP) && w_rx_baud_end;
    assign frame_err        = r_frame_err;
    assign rx_ovf           = r_rx_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rx_state <= RX_IDLE;
        else      r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
            RX_START: if (w_rx_baud_end) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (w_rx_baud_end && r_rx_bit == c_data_last) begin
`ifdef UART_PARITY_EN
                    w_rx_next = RX_PARITY;
`else
                    w_rx_next = RX_STOP;
`endif
                end
            end
            RX_PARITY: begin
`ifdef UART_PARITY_EN
                if (w_rx_baud_end) w_rx_next = RX_STOP;
`else
                w_rx_next = RX_IDLE;
`endif
            end
            RX_STOP:  if (w_rx_baud_end) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_baud    <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_push       <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par_bit <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_push       <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            r_parity_err <= 1'b0;
            if (r_rx_state == RX_PARITY && w_rx_baud_end) r_rx_par_bit <= r_rx_sync;
`endif
            if (r_rx_state == RX_IDLE) begin
                r_rx_baud <= '0;
                r_rx_bit  <= '0;
            end else begin
                r_rx_baud <= w_rx_baud_end ? '0 : r_rx_baud + 1'b1;
                if (w_rx_next != r_rx_state) r_rx_bit <= '0;
                else if (w_rx_baud_end)      r_rx_bit <= r_rx_bit + 1'b1;
            end
            if (r_rx_state == RX_DATA && w_rx_baud_end)
                r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
            if (w_rx_stop_sample) begin
                if (!r_rx_sync) r_frame_err <= 1'b1;
`ifdef UART_PARITY_EN
                else if (w_rx_par_bad) r_parity_err <= 1'b1;
`endif
                else r_push <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0]   r_mem [RX_FIFO_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr, r_rd_ptr;
    logic                   w_empty, w_full, w_pop, w_push;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                      (r_wr_ptr[c_idx_w-1:0] == r_rd_ptr[c_idx_w-1:0]);
    assign w_pop    = rx_rd & ~w_empty;
    // when full, a simultaneous pop frees the head slot the write lands in
    assign w_push   = r_push & (~w_full | w_pop);
    assign done     = ~w_empty;
    assign data_out = w_empty ? '0 : r_mem[r_rd_ptr[c_idx_w-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_idx_w-1:0]] <= r_rx_shift;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_rx_ovf <= r_push & w_full & ~w_pop;
        end
    end

endmodule
`default_nettype wire
